// File: rtl/rsp_reorder_buffer.sv
// Response reorder buffer: execution-unit responses may return in any order,
// and this buffer presents them to the consumer in the order the ids were issued.
// There are eight id slots (outstanding/done/data) and an eight-deep issue-order
// FIFO of ids. The FIFO head is the next id that may leave the buffer.
module rsp_reorder_buffer #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              issue,
    input  logic [2:0]        issue_id,
    output logic              issue_ready,
    input  logic              rsp,
    input  logic [2:0]        rsp_id,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_id,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);

    localparam int NUM_IDS = 8;

    logic [NUM_IDS-1:0] outstanding, outstanding_nxt;
    logic [NUM_IDS-1:0] done, done_nxt;
    logic [DATA_W-1:0]  data_q  [NUM_IDS];
    logic [2:0]         order_q [NUM_IDS];
    logic [2:0]         rd_ptr, wr_ptr;
    logic [3:0]         count;
    logic               err_q;

    logic [2:0] head;
    logic       pop;
    logic       push;
    logic       issue_bad;
    logic       rsp_ok;
    logic       rsp_bad;

    assign head        = order_q[rd_ptr];
    assign out_valid   = (count != 4'd0) && done[head];
    assign pop         = out_valid && out_ready;
    assign issue_ready = (count < 4'd8) || pop;

    // An id may be reissued in the same cycle that it is popped from the head.
    assign push      = issue && issue_ready &&
                       (!outstanding[issue_id] || (pop && (issue_id == head)));
    assign issue_bad = issue && !push;

    assign rsp_ok  = rsp && outstanding[rsp_id] && !done[rsp_id];
    assign rsp_bad = rsp && !rsp_ok;

    assign out_id   = head;
    assign out_data = out_valid ? data_q[head] : '0;
    assign err      = err_q;

    // Next-state slot flags. These are applied in order: pop clear, rsp set,
    // then push. Because push is applied last, a reissue of the popped id
    // leaves it outstanding and not done.
    always_comb begin
        outstanding_nxt = outstanding;
        done_nxt        = done;
        if (pop) begin
            outstanding_nxt[head] = 1'b0;
            done_nxt[head]        = 1'b0;
        end
        if (rsp_ok) begin
            done_nxt[rsp_id] = 1'b1;
        end
        if (push) begin
            outstanding_nxt[issue_id] = 1'b1;
            done_nxt[issue_id]        = 1'b0;
        end
    end

    // Control state: slot flags, order FIFO, pointers, occupancy and sticky error.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            outstanding <= '0;
            done        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_IDS; i++) begin
                order_q[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_nxt;
            done        <= done_nxt;
            if (push) begin
                order_q[wr_ptr] <= issue_id;
                wr_ptr          <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (issue_bad || rsp_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    // Response data storage. It is not reset because a slot's data is only
    // visible after its done bit has been set.
    always_ff @(posedge clk) begin
        if (rsp_ok) begin
            data_q[rsp_id] <= rsp_data;
        end
    end

endmodule

// File: tb/tb_rsp_reorder_buffer.sv
// Scoreboard bench for rsp_reorder_buffer. Directed stimulus pushes the
// expected in-order responses into a queue. A negedge monitor compares each
// accepted output against the queue.
module tb_rsp_reorder_buffer;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              issue;
    logic [2:0]        issue_id;
    logic              issue_ready;
    logic              rsp;
    logic [2:0]        rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_id;
    logic [DATA_W-1:0] out_data;
    logic              err;

    typedef struct {
        logic [2:0]        id;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    rsp_reorder_buffer #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .issue      (issue),
        .issue_id   (issue_id),
        .issue_ready(issue_ready),
        .rsp        (rsp),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_data   (out_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_out(input logic [2:0] id, input logic [DATA_W-1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Advance one clock edge and land 1 ns after it, with the one-shot strobes cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        issue = 1'b0;
        rsp   = 1'b0;
    endtask

    task automatic do_issue(input logic [2:0] id);
        issue    = 1'b1;
        issue_id = id;
        tick();
    endtask

    task automatic do_rsp(input logic [2:0] id, input logic [DATA_W-1:0] d);
        rsp      = 1'b1;
        rsp_id   = id;
        rsp_data = d;
        tick();
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        #2;
        rst_b = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every accepted output must match the head of the scoreboard,
    // and out_data must be zero whenever out_valid is low.
    initial begin
        forever begin
            @(negedge clk);
            if (!out_valid) begin
                check("idle_data_zero", out_data, '0);
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop_id", 64'(out_id), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pop_id", 64'(out_id), 64'(e.id));
                    check("pop_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        rst_b     = 1'b0;
        issue     = 1'b0;
        issue_id  = '0;
        rsp       = 1'b0;
        rsp_id    = '0;
        rsp_data  = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        check("rst_out_id", 64'(out_id), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        #10;
        rst_b = 1'b1;
        tick();

        // In-order case: each output appears one cycle after its response.
        out_ready = 1'b1;
        do_issue(3'd0);
        do_issue(3'd1);
        expect_out(3'd0, 64'h5);
        rsp = 1'b1; rsp_id = 3'd0; rsp_data = 64'h5;
        #1;
        check("inord_no_comb_valid", 64'(out_valid), 64'd0);
        tick();
        check("inord_valid_after_edge", 64'(out_valid), 64'd1);
        check("inord_id0", 64'(out_id), 64'd0);
        expect_out(3'd1, 64'h7);
        do_rsp(3'd1, 64'h7);
        check("inord_valid1", 64'(out_valid), 64'd1);
        check("inord_id1", 64'(out_id), 64'd1);
        wait_drain("inord_drain", 10);

        // Out-of-order completion: output is held until the head response arrives.
        do_issue(3'd2);
        do_issue(3'd5);
        do_rsp(3'd5, 64'hAA);
        check("ooo_held", 64'(out_valid), 64'd0);
        expect_out(3'd2, 64'hBB);
        expect_out(3'd5, 64'hAA);
        do_rsp(3'd2, 64'hBB);
        check("ooo_head_id", 64'(out_id), 64'd2);
        wait_drain("ooo_drain", 10);
        check("ooo_err", 64'(err), 64'd0);

        // Full buffer, a dropped reissue, then an accepted reissue during a pop.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_issue(3'(i));
        check("full_not_ready", 64'(issue_ready), 64'd0);
        check("full_err_clean", 64'(err), 64'd0);
        do_issue(3'd0);
        check("full_drop_err", 64'(err), 64'd1);
        do_rsp(3'd0, 64'h11);
        check("full_head_valid", 64'(out_valid), 64'd1);
        expect_out(3'd0, 64'h11);
        out_ready = 1'b1;
        issue     = 1'b1;
        issue_id  = 3'd0;
        #1;
        check("full_ready_on_pop", 64'(issue_ready), 64'd1);
        tick();
        out_ready = 1'b0;
        #1;
        check("full_count_stays8", 64'(issue_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            expect_out(3'(i), 64'h20 + 64'(i));
            do_rsp(3'(i), 64'h20 + 64'(i));
        end
        expect_out(3'd0, 64'h30);
        do_rsp(3'd0, 64'h30);
        wait_drain("full_drain", 12);

        // Back-pressure: the held output stays stable, then exactly one pop occurs.
        do_reset();
        check("bp_err_cleared", 64'(err), 64'd0);
        out_ready = 1'b0;
        do_issue(3'd3);
        expect_out(3'd3, 64'h33);
        issue = 1'b1; issue_id = 3'd6;
        do_rsp(3'd3, 64'h33);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_id", 64'(out_id), 64'd3);
            check("bp_data", out_data, 64'h33);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_single_pop", 64'(out_valid), 64'd0);
        check("bp_sb_after_pop", 64'(exp_q.size()), 64'd0);
        expect_out(3'd6, 64'h66);
        do_rsp(3'd6, 64'h66);
        out_ready = 1'b1;
        wait_drain("bp_drain", 10);

        // Protocol errors: a response for an id that was never issued, and a
        // duplicate response for an id that is already done.
        do_reset();
        do_rsp(3'd3, 64'hDEAD);
        check("perr_unissued_err", 64'(err), 64'd1);
        check("perr_no_output", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        do_issue(3'd4);
        do_rsp(3'd4, 64'h44);
        do_rsp(3'd4, 64'h99);
        check("perr_dup_id", 64'(out_id), 64'd4);
        check("perr_dup_data", out_data, 64'h44);
        expect_out(3'd4, 64'h44);
        out_ready = 1'b1;
        wait_drain("perr_drain", 10);

        // Reset asserted mid-cycle with entries pending.
        do_reset();
        do_rsp(3'd7, 64'h1);
        check("mrst_pre_err", 64'(err), 64'd1);
        out_ready = 1'b1;
        do_issue(3'd1);
        do_issue(3'd2);
        do_issue(3'd3);
        do_rsp(3'd2, 64'h22);
        check("mrst_pre_valid", 64'(out_valid), 64'd0);
        #3;
        rst_b = 1'b0;
        #1;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_issue_ready", 64'(issue_ready), 64'd1);
        check("mrst_err", 64'(err), 64'd0);
        check("mrst_out_data", out_data, 64'd0);
        #2;
        rst_b = 1'b1;
        tick();
        do_rsp(3'd1, 64'h77);
        check("mrst_stale_rsp_err", 64'(err), 64'd1);
        check("mrst_stale_no_out", 64'(out_valid), 64'd0);
        do_issue(3'd1);
        expect_out(3'd1, 64'h55);
        do_rsp(3'd1, 64'h55);
        wait_drain("mrst_drain", 10);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
